// File: rtl/core_states_pkg.sv
// Core pipeline states shared by the scheduler and the per-thread units.
// Only REQUEST and UPDATE matter to the load/store unit.
package core_states_pkg;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      REQUEST = 3'd2,
      WAIT    = 3'd3,
      EXECUTE = 3'd4,
      UPDATE  = 3'd5,
      DONE    = 3'd6
   } core_state_e;

endpackage

// File: rtl/lsu_states_pkg.sv
// Load/store unit states, shared with the core scheduler
// so it can wait for every LSU to reach DONE.
package lsu_states_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      REQUESTING = 3'd1,
      WAITING    = 3'd2,
      DONE       = 3'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one valid/ready request
// into a memory-controller slot and returns load data.
module lsu
   import lsu_states_pkg::*;
#(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [2:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   localparam int CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   lsu_state_e    state;
   logic          is_load;
   logic [CW-1:0] cnt;

   logic req_go;
   logic ready;
   logic timeout_hit;

   always_comb begin
      req_go = enable
         && (core_state == core_states_pkg::REQUEST)
         && (decoded_mem_read_enable || decoded_mem_write_enable);
      ready = is_load ? mem_read_ready : mem_write_ready;
      // Abort in the cycle the count would reach the limit
      timeout_hit = (TIMEOUT_CYCLES != 0)
         && ((int'(cnt) + 1) >= TIMEOUT_CYCLES);
   end

   assign lsu_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         is_load           <= 1'b0;
         cnt               <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         lsu_out           <= '0;
         lsu_error         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_go) begin
                  state     <= REQUESTING;
                  is_load   <= decoded_mem_read_enable;
                  lsu_error <= 1'b0;
               end
            end
            // Hold off until the previous response's ready has dropped
            REQUESTING: begin
               if (is_load && !mem_read_ready) begin
                  mem_read_valid   <= 1'b1;
                  mem_read_address <= rs[ADDR_BITS-1:0];
                  state            <= WAITING;
               end else if (!is_load && !mem_write_ready) begin
                  mem_write_valid   <= 1'b1;
                  mem_write_address <= rs[ADDR_BITS-1:0];
                  mem_write_data    <= rt;
                  state             <= WAITING;
               end
            end
            WAITING: begin
               if (ready) begin
                  mem_read_valid  <= 1'b0;
                  mem_write_valid <= 1'b0;
                  if (is_load) lsu_out <= mem_read_data;
                  cnt   <= '0;
                  state <= DONE;
               end else if (timeout_hit) begin
                  mem_read_valid  <= 1'b0;
                  mem_write_valid <= 1'b0;
                  lsu_error       <= 1'b1;
                  cnt             <= '0;
                  state           <= DONE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (core_state == core_states_pkg::UPDATE)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of whole transactions
// plus hand sequences for stale ready and async reset.
module tb_lsu;
   import lsu_states_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  core_state = 3'd0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] rs = '0;
   logic [15:0] rt = '0;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready = 1'b0;
   logic [15:0] mem_read_data = '0;
   logic        mem_write_valid;
   logic [7:0]  mem_write_address;
   logic [15:0] mem_write_data;
   logic        mem_write_ready = 1'b0;
   logic [2:0]  lsu_state;
   logic [15:0] lsu_out;
   logic        lsu_error;

   localparam logic [2:0] C_FETCH   = 3'd0;
   localparam logic [2:0] C_REQUEST = 3'd2;
   localparam logic [2:0] C_WAIT    = 3'd3;
   localparam logic [2:0] C_UPDATE  = 3'd5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu #(
      .ADDR_BITS(8),
      .DATA_BITS(16),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .core_state(core_state),
      .decoded_mem_read_enable(rd_en),
      .decoded_mem_write_enable(wr_en),
      .rs(rs),
      .rt(rt),
      .mem_read_valid(mem_read_valid),
      .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready),
      .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid),
      .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data),
      .mem_write_ready(mem_write_ready),
      .lsu_state(lsu_state),
      .lsu_out(lsu_out),
      .lsu_error(lsu_error)
   );

   // Memory responder: ready after lat valid cycles, drops
   // once valid falls (optionally held hold extra cycles).
   int          rd_lat = 1;
   int          wr_lat = 1;
   int          rd_hold = 0;
   int          wr_hold = 0;
   int          rcnt = 0;
   int          wcnt = 0;
   logic [15:0] rd_resp = '0;

   always @(posedge clk) begin
      if (mem_read_valid && !mem_read_ready) begin
         rcnt++;
         if (rcnt >= rd_lat) begin
            mem_read_ready <= 1'b1;
            mem_read_data  <= rd_resp;
         end
      end else if (!mem_read_valid) begin
         rcnt = 0;
         if (mem_read_ready) begin
            if (rd_hold > 0) rd_hold--;
            else mem_read_ready <= 1'b0;
         end
      end
      if (mem_write_valid && !mem_write_ready) begin
         wcnt++;
         if (wcnt >= wr_lat) mem_write_ready <= 1'b1;
      end else if (!mem_write_valid) begin
         wcnt = 0;
         if (mem_write_ready) begin
            if (wr_hold > 0) wr_hold--;
            else mem_write_ready <= 1'b0;
         end
      end
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic        en;
      logic        drop_en;
      logic [15:0] a;
      logic [15:0] d;
      int          lat;
      logic [15:0] resp;
      logic        x_done;
      int          x_rvc;
      int          x_wvc;
      logic [7:0]  x_addr;
      logic [15:0] x_wdata;
      logic [15:0] x_out;
      logic        x_err;
   } vec_t;

   // One transaction from REQUEST to IDLE, observed at negedges
   task automatic run_txn(
      input  logic rd, input logic wr, input logic en,
      input  logic drop_en,
      input  logic [15:0] a, input logic [15:0] d,
      input  int budget,
      output logic done, output int rvc, output int wvc,
      output logic [7:0] addr, output logic [15:0] wdata,
      output logic stable, output logic stale_taken,
      output logic saw_stale, output logic idle_ok);
      int c;
      done = 0; rvc = 0; wvc = 0; addr = '0; wdata = '0;
      stable = 1; stale_taken = 0; saw_stale = 0; c = 0;
      @(negedge clk);
      enable = en; rd_en = rd; wr_en = wr;
      rs = a; rt = d; core_state = C_REQUEST;
      @(negedge clk);
      core_state = C_WAIT;
      if (drop_en) enable = 1'b0;
      while (!done && c < budget) begin
         if (mem_read_valid) begin
            if (rvc == 0) begin
               addr = mem_read_address;
               stale_taken = mem_read_ready;
            end else if (mem_read_address !== addr) stable = 0;
            rvc++;
         end
         if (mem_write_valid) begin
            if (wvc == 0) begin
               addr  = mem_write_address;
               wdata = mem_write_data;
               stale_taken = mem_write_ready;
            end else if (mem_write_address !== addr
                         || mem_write_data !== wdata) stable = 0;
            wvc++;
         end
         if (lsu_state == REQUESTING && !mem_read_valid
             && mem_read_ready) saw_stale = 1;
         if (lsu_state == DONE) done = 1;
         else begin
            @(negedge clk);
            c++;
         end
      end
      if (done) begin
         core_state = C_UPDATE;
         @(negedge clk);
      end
      core_state = C_FETCH;
      idle_ok = (lsu_state == IDLE);
   endtask

   vec_t vecs[8];

   initial begin
      logic        done, stable, stale_taken, saw_stale, idle_ok;
      int          rvc, wvc;
      logic [7:0]  addr;
      logic [15:0] wdata;

      vecs[0] = '{1,0,1,0,16'h0012,16'h0000,3,16'hBEEF,
                  1,4,0,8'h12,16'h0000,16'hBEEF,0};
      vecs[1] = '{0,1,1,0,16'h00FF,16'h1234,2,16'h0000,
                  1,0,3,8'hFF,16'h1234,16'hBEEF,0};
      vecs[2] = '{1,1,1,1,16'h1234,16'h9999,1,16'h5A5A,
                  1,2,0,8'h34,16'h0000,16'h5A5A,0};
      vecs[3] = '{1,0,0,0,16'h0044,16'h0000,1,16'h7777,
                  0,0,0,8'h00,16'h0000,16'h5A5A,0};
      vecs[4] = '{1,0,1,0,16'hAB40,16'h0000,100,16'hDEAD,
                  1,4,0,8'h40,16'h0000,16'h5A5A,1};
      vecs[5] = '{1,0,1,0,16'h0001,16'h0000,1,16'h0F0F,
                  1,2,0,8'h01,16'h0000,16'h0F0F,0};
      vecs[6] = '{0,1,1,0,16'h0077,16'hCAFE,100,16'h0000,
                  1,0,4,8'h77,16'hCAFE,16'h0F0F,1};
      vecs[7] = '{0,1,1,0,16'h1080,16'h0000,1,16'h0000,
                  1,0,2,8'h80,16'h0000,16'h0F0F,0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(lsu_state), 32'(IDLE));
      chk("reset_outs",
          {mem_read_valid, mem_write_valid, lsu_error,
           mem_read_address, mem_write_address},
          32'h0);
      chk("reset_data", {mem_write_data, lsu_out}, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         rd_lat = vecs[i].lat;
         wr_lat = vecs[i].lat;
         rd_resp = vecs[i].resp;
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].en,
                 vecs[i].drop_en, vecs[i].a, vecs[i].d,
                 vecs[i].x_done ? 30 : 6,
                 done, rvc, wvc, addr, wdata,
                 stable, stale_taken, saw_stale, idle_ok);
         chk($sformatf("v%0d done", i), 32'(done),
             32'(vecs[i].x_done));
         chk($sformatf("v%0d rvalid_cyc", i), rvc,
             vecs[i].x_rvc);
         chk($sformatf("v%0d wvalid_cyc", i), wvc,
             vecs[i].x_wvc);
         chk($sformatf("v%0d addr", i), 32'(addr),
             32'(vecs[i].x_addr));
         chk($sformatf("v%0d wdata", i), 32'(wdata),
             32'(vecs[i].x_wdata));
         chk($sformatf("v%0d stable", i), 32'(stable), 32'd1);
         chk($sformatf("v%0d stale", i), 32'(stale_taken),
             32'd0);
         chk($sformatf("v%0d out", i), 32'(lsu_out),
             32'(vecs[i].x_out));
         chk($sformatf("v%0d err", i), 32'(lsu_error),
             32'(vecs[i].x_err));
         chk($sformatf("v%0d idle", i), 32'(idle_ok), 32'd1);
      end

      // Back-to-back loads with ready lingering from the first
      rd_lat = 1; rd_resp = 16'h1111; rd_hold = 3;
      run_txn(1, 0, 1, 0, 16'h0021, 16'h0, 30, done, rvc, wvc,
              addr, wdata, stable, stale_taken, saw_stale,
              idle_ok);
      chk("b2b first out", 32'(lsu_out), 32'h1111);
      rd_resp = 16'h2222;
      run_txn(1, 0, 1, 0, 16'h0022, 16'h0, 30, done, rvc, wvc,
              addr, wdata, stable, stale_taken, saw_stale,
              idle_ok);
      chk("b2b saw stale ready", 32'(saw_stale), 32'd1);
      chk("b2b valid under stale", 32'(stale_taken), 32'd0);
      chk("b2b rvalid_cyc", rvc, 2);
      chk("b2b addr", 32'(addr), 32'h22);
      chk("b2b out", 32'(lsu_out), 32'h2222);

      // Asynchronous reset while WAITING
      rd_lat = 100;
      @(negedge clk);
      enable = 1; rd_en = 1; wr_en = 0; rs = 16'h0099;
      core_state = C_REQUEST;
      @(negedge clk);
      core_state = C_WAIT;
      @(negedge clk);
      chk("rst pre state", 32'(lsu_state), 32'(WAITING));
      chk("rst pre valid", 32'(mem_read_valid), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst async state", 32'(lsu_state), 32'(IDLE));
      chk("rst async outs",
          {mem_read_valid, mem_write_valid, lsu_error,
           mem_read_address, mem_write_address},
          32'h0);
      chk("rst async data", {mem_write_data, lsu_out}, 32'h0);
      @(negedge clk);
      core_state = C_FETCH; rd_lat = 1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst release idle", 32'(lsu_state), 32'(IDLE));
      chk("rst release valid", 32'(mem_read_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
